// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcodes, control states and FLAGS bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle, WIDTH cycles per product.
// prod_o is the combinational result of the current step; done_o flags the final step, which stall_i can hold.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic                 stall_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = acc_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q && !(done_o && stall_i)) begin
      // Final step freezes while the consumer still holds the previous result.
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops registered in 1 cycle, MUL in WIDTH cycles; output held while OUT_READY=0.
// ALU_SAT_EN defined: ADD/SUB saturate (C keeps raw carry/borrow, V cleared on clamp); undefined: they wrap.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RES,
  output logic [WIDTH-1:0] RES_HI,
  output logic [3:0]       FLAGS
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q;
  logic               out_vld_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  logic [3:0]         flags_q;

  opcode_e            op;
  logic               out_free;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;

  logic [CW-1:0]      shamt;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   res_c;
  logic               c_c;
  logic               v_c;
  logic [3:0]         flags_c;
  logic [3:0]         mul_flags;

  assign op       = opcode_e'(OPCODE);
  assign out_free = !out_vld_q || OUT_READY;
  assign IN_READY = (state_q == S_IDLE) && out_free;
  assign accept   = IN_VALID && IN_READY;

  assign OUT_VALID = out_vld_q;
  assign RES       = res_q;
  assign RES_HI    = hi_q;
  assign FLAGS     = flags_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (accept && (op == OP_MUL)),
    .stall_i (!out_free),
    .a_i     (OP1),
    .b_i     (OP2),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  // Extra top/bottom bit captures carry, borrow or the last bit shifted out.
  assign shamt  = OP2[CW-1:0];
  assign sum_w  = {1'b0, OP1} + {1'b0, OP2};
  assign diff_w = {1'b0, OP1} - {1'b0, OP2};
  assign shl_w  = {1'b0, OP1} << shamt;
  assign shr_w  = {OP1, 1'b0} >> shamt;

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum_w[WIDTH-1] != OP1[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (sum_w[WIDTH]) begin
          res_c = '1;
          v_c   = 1'b0;
        end
`endif
      end
      OP_SUB: begin
        res_c = diff_w[WIDTH-1:0];
        c_c   = diff_w[WIDTH];
        v_c   = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff_w[WIDTH-1] != OP1[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (diff_w[WIDTH]) begin
          res_c = '0;
          v_c   = 1'b0;
        end
`endif
      end
      OP_AND: res_c = OP1 & OP2;
      OP_OR:  res_c = OP1 | OP2;
      OP_XOR: res_c = OP1 ^ OP2;
      OP_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_w[WIDTH:1];
        c_c   = shr_w[0];
      end
      OP_MUL: res_c = '0;
    endcase

    flags_c         = '0;
    flags_c[FLAG_V] = v_c;
    flags_c[FLAG_N] = res_c[WIDTH-1];
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_C] = c_c;

    mul_flags         = '0;
    mul_flags[FLAG_N] = prod[WIDTH-1];
    mul_flags[FLAG_Z] = (prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = (prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      hi_q      <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept && (op == OP_MUL)) state_q <= S_MUL;
        S_MUL:  if (mul_done && out_free)     state_q <= S_IDLE;
      endcase

      if (accept && (op != OP_MUL)) begin
        out_vld_q <= 1'b1;
        res_q     <= res_c;
        hi_q      <= '0;
        flags_q   <= flags_c;
      end else if ((state_q == S_MUL) && mul_done && out_free) begin
        out_vld_q <= 1'b1;
        res_q     <= prod[WIDTH-1:0];
        hi_q      <= prod[2*WIDTH-1:WIDTH];
        flags_q   <= mul_flags;
      end else if (OUT_READY) begin
        out_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vector bench for alu_pipe at WIDTH=4: table of single-cycle ops plus MUL/backpressure/reset sequences.
module tb_alu_pipe;

  logic       clk;
  logic       rstn;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] OPCODE;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] RES;
  logic [3:0] RES_HI;
  logic [3:0] FLAGS;

  int n_chk  = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OPCODE    (OPCODE),
    .OP1       (OP1),
    .OP2       (OP2),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RES       (RES),
    .RES_HI    (RES_HI),
    .FLAGS     (FLAGS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] flg;  // {V,N,Z,C}
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    IN_VALID = v;
    OPCODE   = op;
    OP1      = a;
    OP2      = b;
  endtask

  task automatic do_mul(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] flg);
    chk({nm, " ready before"}, IN_READY, 1);
    drive(1'b1, 3'b111, a, b);
    tick();
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s busy IN_READY c%0d", nm, k), IN_READY, 0);
      chk($sformatf("%s busy OUT_VALID c%0d", nm, k), OUT_VALID, 0);
      tick();
    end
    chk({nm, " OUT_VALID"}, OUT_VALID, 1);
    chk({nm, " RES"}, RES, lo);
    chk({nm, " RES_HI"}, RES_HI, hi);
    chk({nm, " FLAGS"}, FLAGS, flg);
    chk({nm, " IN_READY after"}, IN_READY, 1);
  endtask

  initial begin
`ifdef ALU_SAT_EN
    tbl[0]  = '{3'b000, 4'hF, 4'h1, 4'hF, 4'b0101};
    tbl[1]  = '{3'b001, 4'h3, 4'h5, 4'h0, 4'b0011};
    tbl[12] = '{3'b000, 4'h8, 4'h8, 4'hF, 4'b0101};
`else
    tbl[0]  = '{3'b000, 4'hF, 4'h1, 4'h0, 4'b0011};
    tbl[1]  = '{3'b001, 4'h3, 4'h5, 4'hE, 4'b0101};
    tbl[12] = '{3'b000, 4'h8, 4'h8, 4'h0, 4'b1011};
`endif
    tbl[2]  = '{3'b000, 4'h7, 4'h1, 4'h8, 4'b1100};
    tbl[3]  = '{3'b010, 4'hC, 4'hA, 4'h8, 4'b0100};
    tbl[4]  = '{3'b011, 4'h0, 4'h0, 4'h0, 4'b0010};
    tbl[5]  = '{3'b100, 4'hA, 4'h5, 4'hF, 4'b0100};
    tbl[6]  = '{3'b101, 4'hB, 4'h1, 4'h6, 4'b0001};
    tbl[7]  = '{3'b101, 4'h9, 4'h4, 4'h9, 4'b0100};  // shamt uses OP2[1:0] only -> 0
    tbl[8]  = '{3'b110, 4'hB, 4'h2, 4'h2, 4'b0001};
    tbl[9]  = '{3'b110, 4'h8, 4'h3, 4'h1, 4'b0000};
    tbl[10] = '{3'b001, 4'h5, 4'h5, 4'h0, 4'b0010};
    tbl[11] = '{3'b001, 4'h8, 4'h1, 4'h7, 4'b1000};
    tbl[13] = '{3'b101, 4'h1, 4'h3, 4'h8, 4'b0100};

    // Reset with a MUL request pending
    rstn      = 1'b0;
    OUT_READY = 1'b1;
    drive(1'b1, 3'b111, 4'hF, 4'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("reset OUT_VALID c%0d", k), OUT_VALID, 0);
      chk($sformatf("reset RES c%0d", k), RES, 0);
      chk($sformatf("reset RES_HI c%0d", k), RES_HI, 0);
      chk($sformatf("reset FLAGS c%0d", k), FLAGS, 0);
    end
    rstn = 1'b1;
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    chk("release IN_READY", IN_READY, 1);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("vec%0d IN_READY", i), IN_READY, 1);
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      tick();
      chk($sformatf("vec%0d OUT_VALID", i), OUT_VALID, 1);
      chk($sformatf("vec%0d RES", i), RES, tbl[i].res);
      chk($sformatf("vec%0d RES_HI", i), RES_HI, 0);
      chk($sformatf("vec%0d FLAGS", i), FLAGS, tbl[i].flg);
    end
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    tick();
    chk("drain OUT_VALID", OUT_VALID, 0);

    do_mul("mul FxF", 4'hF, 4'hF, 4'h1, 4'hE, 4'b0001);
    tick();
    do_mul("mul 3x5", 4'h3, 4'h5, 4'hF, 4'h0, 4'b0100);
    tick();

    // Output backpressure: XOR held for 3 cycles, pending ADD must wait
    OUT_READY = 1'b0;
    drive(1'b1, 3'b100, 4'hA, 4'h5);
    tick();
    drive(1'b1, 3'b000, 4'h1, 4'h1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp OUT_VALID c%0d", k), OUT_VALID, 1);
      chk($sformatf("bp RES c%0d", k), RES, 4'hF);
      chk($sformatf("bp FLAGS c%0d", k), FLAGS, 4'b0100);
      chk($sformatf("bp IN_READY c%0d", k), IN_READY, 0);
      tick();
    end
    chk("bp held RES", RES, 4'hF);
    OUT_READY = 1'b1;
    #1;
    chk("bp release IN_READY", IN_READY, 1);
    tick();
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    chk("bp next OUT_VALID", OUT_VALID, 1);
    chk("bp next RES", RES, 4'h2);
    tick();

    // Reset in the middle of a MUL discards it
    drive(1'b1, 3'b111, 4'h3, 4'h5);
    tick();
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    chk("mulrst busy IN_READY", IN_READY, 0);
    tick();
    rstn = 1'b0;
    tick();
    chk("mulrst in reset OUT_VALID", OUT_VALID, 0);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("mulrst no output c%0d", k), OUT_VALID, 0);
      chk($sformatf("mulrst IN_READY c%0d", k), IN_READY, 1);
      tick();
    end
    drive(1'b1, 3'b000, 4'h1, 4'h1);
    tick();
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    chk("post-rst ADD OUT_VALID", OUT_VALID, 1);
    chk("post-rst ADD RES", RES, 4'h2);
    chk("post-rst ADD FLAGS", FLAGS, 4'b0000);
    chk("post-rst ADD RES_HI", RES_HI, 4'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
